// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// with registered busy/done flags and result outputs that hold between operations.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for start
  // SHIFT | one difference bit per cycle, WIDTH cycles
  // DONE  | one-cycle done pulse; a new start may be accepted here
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic diff_bit;
  logic br_next;
  logic accept;

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;

    diff_bit = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    br_next  = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);

    case (state_q)
      IDLE: accept = start;
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = {diff_bit, res_q[WIDTH-1:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          d_d     = {diff_bit, res_q[WIDTH-1:1]};
          bout_d  = br_next;
          // diff_bit is the result MSB; operand MSBs were saved at capture
          ovf_d   = (a_msb_q ^ b_msb_q) & (diff_bit ^ a_msb_q);
        end
      end
      DONE: begin
        state_d = IDLE;
        accept  = start;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = SHIFT;
      a_sr_d  = a;
      b_sr_d  = b;
      res_d   = '0;
      br_d    = bin;
      cnt_d   = '0;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, ovf;
  logic [W-1:0] d;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pulse at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_d", 32'(d), 32'(e.d));
        check("result_bout", 32'(bout), 32'(e.bout));
        check("result_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  // call at a negedge: this cycle becomes cycle 0 of the operation
  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini,
                       input logic [W-1:0] ed, input logic eb, input logic eo);
    a = ai; b = bi; bin = bini; start = 1'b1;
    exp_q.push_back('{d: ed, bout: eb, ovf: eo});
  endtask

  // walks cycles 1..W (busy, outputs holding) and lands on the done cycle W+1
  task automatic expect_latency(input logic [W-1:0] hold_d);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      check("busy_shift", 32'(busy), 32'd1);
      check("no_early_done", 32'(done), 32'd0);
      check("d_hold", 32'(d), 32'(hold_d));
      @(negedge clk);
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    expect_latency(8'h00);
    @(negedge clk);
    check("idle_after_done", 32'(done), 32'd0);

    issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    expect_latency(8'h1E);
    @(negedge clk);

    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    expect_latency(8'hFF);
    @(negedge clk);
    issue(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    expect_latency(8'h7F);
    @(negedge clk);

    // start while busy is ignored; input changes after capture are harmless
    dc0 = done_cnt;
    issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; a = 8'hAA; b = 8'h55;
    for (int k = 4; k <= W; k++) begin
      check("busy_ignore", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("done_ignore", 32'(done), 32'd1);
    repeat (12) @(negedge clk);
    check("single_done", 32'(done_cnt - dc0), 32'd1);

    // reset mid-SHIFT aborts without a done pulse
    dc0 = done_cnt;
    a = 8'h22; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_d", 32'(d), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    issue(8'h22, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0);
    expect_latency(8'h00);
    @(negedge clk);

    // back-to-back accept in the DONE cycle
    issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    expect_latency(8'h11);
    issue(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0);
    expect_latency(8'h80);
    @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to begin a subtraction; sampled only when busy=0.
REQ-006 a  input  WIDTH  minuend; captured on an accepted start.
REQ-007 b  input  WIDTH  subtrahend; captured on an accepted start.
REQ-008 bin  input  1  borrow-in; captured on an accepted start.
REQ-009 busy  output  1  high while bit-serial computation is in progress.
REQ-010 done  output  1  single-cycle pulse: result outputs updated this cycle.
REQ-011 d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
REQ-012 bout  output  1  borrow-out: 1 iff a < b + bin (unsigned).
REQ-013 ovf  output  1  two's-complement overflow of the signed subtraction.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-015 IDLE: busy=0 and done=0; start=1 SHALL capture a, b and bin into internal shift registers, seed the borrow register with bin, clear the bit counter, and move to SHIFT.
REQ-016 SHIFT: busy=1; each cycle SHALL process one bit, LSB first: diff = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-017 SHIFT SHALL shift each diff bit into the internal result register from the MSB end and SHALL last exactly WIDTH cycles, leaving on counter = WIDTH-1.
REQ-018 On leaving SHIFT, d, bout and ovf SHALL be loaded from the result register, the final borrow and ovf = (a[MSB]^b[MSB]) & (d[MSB]^a[MSB]) using the captured operands; the FSM moves to DONE.
REQ-019 DONE: done=1 and busy=0 for exactly one cycle; the next state SHALL be IDLE, or SHIFT if start=1 in this cycle (back-to-back accept, same capture as REQ-015).
REQ-020 Latency: if start is accepted in cycle 0, busy SHALL be 1 in cycles 1..WIDTH and done SHALL be 1 in cycle WIDTH+1.
REQ-021 d, bout and ovf SHALL change only on the transition into DONE and SHALL hold their values otherwise, including while a later operation is in SHIFT.
REQ-022 start while busy=1 SHALL be ignored; changes to a, b and bin after capture SHALL not affect the result.
REQ-023 The borrow chain SHALL be fully modular: wrap-around past zero yields d = (a - b - bin) mod 2^WIDTH with bout=1.

Reset
REQ-024 rst=1 SHALL force IDLE, busy=0, done=0, d=0, bout=0, ovf=0, and clear the counter, borrow and internal registers at the next clock edge.
REQ-025 rst SHALL take priority over start and over any in-progress operation; a reset mid-SHIFT SHALL abort the operation with no done pulse.

Verification
REQ-026 a=0x5A, b=0x3C, bin=0 -> d=0x1E, bout=0, ovf=0, done in cycle 9.
REQ-027 a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1, ovf=0.
REQ-028 a=0x80, b=0x01, bin=0 -> d=0x7F, bout=0, ovf=1; then a=0x10, b=0x0F, bin=1 -> d=0x00, bout=0, ovf=0.
REQ-029 start a=0x05, b=0x03; in cycle 3 pulse start with a=0xFF, b=0x00 -> second start ignored, d=0x02 in cycle 9, exactly one done pulse.
REQ-030 start a=0x22, b=0x11; assert rst in cycle 4 -> busy=0, no done pulse, outputs 0; a new start then yields d=0x11 after 9 cycles.
REQ-031 start held in the DONE cycle with a=0x01, b=0x02 -> accepted; second done 9 cycles later with d=0xFF, bout=1; first result holds until then.
